ave8_sched: RTL and testbench



---
 rtl/ave8_pkg.sv | 12 +
 rtl/ave8_rr_arb.sv | 27 ++
 rtl/ave8_sched.sv | 102 ++++++++++
 tb/tb_ave8_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ave8_pkg.sv
// ave8_pkg: shared states, window constants and width helpers for the 8-tap averaging scheduler
package ave8_pkg;
  typedef enum logic [1:0] {S_CLR, S_IDLE, S_UPD, S_OUT} state_t;
  localparam int TAPS = 8;
  localparam int TAP_LOG2 = 3;
  function automatic int sumw(input int dw);
    return dw + TAP_LOG2;
  endfunction
  function automatic int chw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ave8_rr_arb.sv
// ave8_rr_arb: combinational round-robin pick of the first requester after the last grant
module ave8_rr_arb
  import ave8_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IW  = chw(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic           any
);
  always_comb begin
    int best;
    best = NCH;
    idx = '0;
    for (int k = 0; k < NCH; k++)
      if (req[k] && ((k + 2 * NCH - int'(last) - 1) % NCH) < best) begin
        best = (k + 2 * NCH - int'(last) - 1) % NCH;
        idx = IW'(k);
      end
    any = best < NCH;
    gnt = '0;
    if (any) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/ave8_sched.sv
// ave8_sched: one shared 8-tap moving-average update path time-shared among NCH channels
module ave8_sched
  import ave8_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*DW-1:0]    din,
  output logic [NCH-1:0]       gnt,
  input  logic                 clr,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [chw(NCH)-1:0]  out_ch,
  output logic                 out_full
);
  localparam int IW = chw(NCH);
  localparam int SW = sumw(DW);
  state_t state, state_n;
  logic [TAP_LOG2-1:0] cidx;
  logic [IW-1:0] rr, cur_ch, a_idx;
  logic [DW-1:0] cur_smp;
  logic [NCH-1:0] a_gnt;
  logic a_any, take;
  logic [DW-1:0] hist [NCH][TAPS];
  logic [SW-1:0] sum [NCH];
  logic [TAP_LOG2-1:0] ptr [NCH];
  logic [TAP_LOG2:0] cnt [NCH];
  logic [SW-1:0] sum_new;
  logic [TAP_LOG2:0] cnt_new;

  ave8_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
    .req (req),
    .last(rr),
    .gnt (a_gnt),
    .idx (a_idx),
    .any (a_any)
  );

  always_comb begin
    take = state == S_IDLE && !clr && a_any;
    gnt = take ? a_gnt : '0;
    busy = state == S_CLR;
    sum_new = sum[cur_ch] - SW'(hist[cur_ch][ptr[cur_ch]]) + SW'(cur_smp);
    cnt_new = cnt[cur_ch][TAP_LOG2] ? cnt[cur_ch] : cnt[cur_ch] + 1'b1;
    state_n = state;
    case (state)
      S_CLR:   state_n = &cidx ? S_IDLE : S_CLR;
      S_IDLE:  state_n = clr ? S_CLR : a_any ? S_UPD : S_IDLE;
      S_UPD:   state_n = S_OUT;
      default: state_n = out_ready ? S_IDLE : S_OUT;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET || state == S_CLR) begin
      for (int k = 0; k < NCH; k++) begin
        sum[k] <= '0;
        ptr[k] <= '0;
        cnt[k] <= '0;
        hist[k][cidx] <= '0;
      end
    end else if (state == S_UPD) begin
      hist[cur_ch][ptr[cur_ch]] <= cur_smp;
      ptr[cur_ch] <= ptr[cur_ch] + 1'b1;
      sum[cur_ch] <= sum_new;
      cnt[cur_ch] <= cnt_new;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= S_CLR;
      cidx <= '0;
      rr <= IW'(NCH - 1);
      cur_ch <= '0;
      cur_smp <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      out_full <= 1'b0;
    end else begin
      state <= state_n;
      cidx <= state == S_CLR ? cidx + 1'b1 : '0;
      if (take) begin
        cur_ch <= a_idx;
        cur_smp <= din[a_idx*DW +: DW];
        rr <= a_idx;
      end
      if (state == S_UPD) begin
        out_valid <= 1'b1;
        out_data <= sum_new[SW-1:TAP_LOG2];
        out_ch <= cur_ch;
        out_full <= cnt_new[TAP_LOG2];
      end else if (state == S_OUT && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ave8_sched.sv
// tb_ave8_sched: vector table plus scoreboard check of the shared moving-average scheduler
module tb_ave8_sched;
  localparam int NCH = 4;
  localparam int DW = 8;
  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic [NCH-1:0] req = '0;
  logic [NCH*DW-1:0] din = '0;
  logic [NCH-1:0] gnt;
  logic clr = 1'b0;
  logic busy, out_valid, out_full;
  logic out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [1:0] out_ch;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {int ch; logic [7:0] smp; logic [7:0] data; logic full; bit gap;} vec_t;
  typedef struct {int ch; logic [7:0] data; logic full;} exp_t;
  vec_t vec [24];
  exp_t sb [$];
  exp_t e;

  ave8_sched #(.NCH(NCH), .DW(DW)) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .req      (req),
    .din      (din),
    .gnt      (gnt),
    .clr      (clr),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_full (out_full)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK)
    if (!RESET && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: ch %0d data %0d with empty scoreboard", out_ch, out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_ch", out_ch, e.ch);
        chk("out_full", out_full, e.full);
      end
    end

  task automatic wait_gnt(input logic [NCH-1:0] mask, output logic [NCH-1:0] g);
    g = '0;
    for (int i = 0; i < 60 && g == '0; i++) begin
      @(negedge CLOCK);
      g = gnt & mask;
    end
    if (g == '0) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: no grant for mask %b", mask);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge CLOCK);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
    end
  endtask

  task automatic send(input int ch, input logic [7:0] smp, input logic [7:0] data,
                      input logic full, output int gc);
    logic [NCH-1:0] g;
    @(posedge CLOCK);
    #1;
    req[ch] = 1'b1;
    din[ch*DW +: DW] = smp;
    wait_gnt(4'(1) << ch, g);
    chk("gnt_onehot", gnt, 4'(1) << ch);
    sb.push_back('{ch, data, full});
    gc = cyc;
    @(posedge CLOCK);
    #1 req[ch] = 1'b0;
  endtask

  task automatic run(input int a, input int b);
    int gc;
    int last_gc = 0;
    for (int i = a; i < b; i++) begin
      send(vec[i].ch, vec[i].smp, vec[i].data, vec[i].full, gc);
      if (vec[i].gap) chk("gnt_gap", gc - last_gc, 3);
      last_gc = gc;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] g;
    int ord [5] = '{0, 1, 2, 3, 0};
    int dat [5] = '{5, 5, 5, 5, 10};
    vec = '{
      '{0, 8, 1, 0, 0}, '{0, 8, 2, 0, 1}, '{0, 8, 3, 0, 1}, '{0, 8, 4, 0, 1},
      '{0, 8, 5, 0, 1}, '{0, 8, 6, 0, 1}, '{0, 8, 7, 0, 1}, '{0, 8, 8, 1, 1},
      '{0, 16, 9, 1, 1},
      '{0, 255, 39, 1, 1}, '{0, 255, 70, 1, 1}, '{0, 255, 101, 1, 1}, '{0, 255, 132, 1, 1},
      '{0, 255, 163, 1, 1}, '{0, 255, 194, 1, 1}, '{0, 255, 225, 1, 1}, '{0, 255, 255, 1, 1},
      '{2, 40, 10, 0, 0}, '{2, 40, 15, 0, 1}, '{2, 40, 20, 0, 1}, '{2, 40, 25, 0, 1},
      '{2, 40, 30, 0, 1}, '{2, 40, 35, 0, 1}, '{2, 40, 40, 1, 1}
    };
    do_reset();
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_full", out_full, 0);
    for (int i = 0; i < 8; i++) begin
      chk("clr_busy", busy, 1);
      chk("clr_gnt", gnt, 0);
      chk("clr_out_valid", out_valid, 0);
      @(negedge CLOCK);
    end
    chk("clr_busy_done", busy, 0);
    run(0, 17);
    drain();
    do_reset();
    for (int i = 0; i < 20 && busy; i++) @(negedge CLOCK);
    @(posedge CLOCK);
    #1;
    req = '1;
    din = {4{8'd40}};
    for (int t = 0; t < 5; t++) begin
      wait_gnt('1, g);
      chk("rr_order", gnt, 4'(1) << ord[t]);
      sb.push_back('{ord[t], dat[t], 1'b0});
      @(posedge CLOCK);
    end
    #1 out_ready = 1'b0;
    @(negedge CLOCK);
    repeat (5) begin
      @(negedge CLOCK);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 10);
      chk("stall_ch", out_ch, 0);
      chk("stall_gnt", gnt, 0);
    end
    @(posedge CLOCK);
    #1 out_ready = 1'b1;
    wait_gnt('1, g);
    chk("accepted_before_gnt", sb.size(), 0);
    chk("gnt_after_accept", gnt, 4'b0010);
    sb.push_back('{1, 8'd10, 1'b0});
    @(posedge CLOCK);
    #1 req = '0;
    drain();
    run(17, 24);
    drain();
    @(posedge CLOCK);
    #1;
    req[2] = 1'b1;
    din[2*DW +: DW] = 8'd80;
    clr = 1'b1;
    @(negedge CLOCK);
    chk("clr_req_gnt", gnt, 0);
    @(posedge CLOCK);
    #1 clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK);
      chk("reclr_busy", busy, 1);
      chk("reclr_gnt", gnt, 0);
    end
    wait_gnt(4'b0100, g);
    chk("reclr_busy_done", busy, 0);
    chk("reclr_gnt_ch2", gnt, 4'b0100);
    sb.push_back('{2, 8'd10, 1'b0});
    @(posedge CLOCK);
    #1 req = '0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
